// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the RAM port arbiter: channel indices, transfer
// directions and the arbiter state encoding.
package ram_port_arbiter_pkg;

  localparam logic [1:0] CH_FFT_RD = 2'd0;
  localparam logic [1:0] CH_FFT_WR = 2'd1;
  localparam logic [1:0] CH_FIR_RD = 2'd2;
  localparam logic [1:0] CH_FIR_WR = 2'd3;

  localparam logic DIR_READ  = 1'b0;
  localparam logic DIR_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    TURN  = 2'd1,
    GRANT = 2'd2
  } arb_state_t;

  // Even channel indices are readers, odd ones are writers.
  function automatic logic ch_dir(input logic [1:0] ch);
    return ch[0] ? DIR_WRITE : DIR_READ;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Channel request/grant/address bundle plus the shared RAM port strobes.
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              fft_enable;
  logic              fir_enable;
  logic              fft_rd_req;
  logic              fft_wr_req;
  logic              fir_rd_req;
  logic              fir_wr_req;
  logic [ADDR_W-1:0] fft_rd_addr;
  logic [ADDR_W-1:0] fft_wr_addr;
  logic [ADDR_W-1:0] fir_rd_addr;
  logic [ADDR_W-1:0] fir_wr_addr;
  logic              fft_rd_gnt;
  logic              fft_wr_gnt;
  logic              fir_rd_gnt;
  logic              fir_wr_gnt;
  logic              ram_read_enable;
  logic              ram_write_enable;
  logic [ADDR_W-1:0] addr;
  logic              busy;

  // Requesting side: accelerators driving requests and addresses.
  modport master (
    output fft_enable, fir_enable,
    output fft_rd_req, fft_wr_req, fir_rd_req, fir_wr_req,
    output fft_rd_addr, fft_wr_addr, fir_rd_addr, fir_wr_addr,
    input  fft_rd_gnt, fft_wr_gnt, fir_rd_gnt, fir_wr_gnt,
    input  ram_read_enable, ram_write_enable, addr, busy
  );

  // Arbiter side.
  modport slave (
    input  fft_enable, fir_enable,
    input  fft_rd_req, fft_wr_req, fir_rd_req, fir_wr_req,
    input  fft_rd_addr, fft_wr_addr, fir_rd_addr, fir_wr_addr,
    output fft_rd_gnt, fft_wr_gnt, fir_rd_gnt, fir_wr_gnt,
    output ram_read_enable, ram_write_enable, addr, busy
  );
endinterface

// File: rtl/ram_port_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set request after rr_ptr, mod 4.
module rr_pick4 (
  input  logic [3:0] i_req,
  input  logic [1:0] i_rr_ptr,
  output logic [1:0] o_winner,
  output logic       o_valid
);

  // Scan rr_ptr+1 .. rr_ptr+4 and keep the first hit.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves
    // it unassigned, which would otherwise infer a latch.
    o_winner = 2'd0;
    o_valid  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!o_valid && i_req[i_rr_ptr + 2'(k)]) begin
        o_winner = i_rr_ptr + 2'(k);
        o_valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one RAM port between FFT/FIR read/write channels with round-robin
// arbitration, bounded bursts and bus-turnaround gaps on direction changes.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int MAX_BURST   = 8,
  parameter int TURN_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  ram_port_arbiter_if.slave bus
);

  arb_state_t  r_state, w_state_nxt;
  logic [3:0]  r_gnt, w_gnt_nxt;
  logic [1:0]  r_rr_ptr, w_rr_ptr_nxt;
  logic        r_last_dir, w_last_dir_nxt;
  logic [7:0]  r_beat_cnt, w_beat_cnt_nxt;
  logic [1:0]  r_turn_cnt, w_turn_cnt_nxt;
  logic [1:0]  r_winner, w_winner_nxt;

  logic [3:0]        w_eff_req;
  logic [ADDR_W-1:0] w_ch_addr [4];
  logic [1:0]        w_pick;
  logic              w_pick_valid;
  logic              w_beat;

  assign w_eff_req[CH_FFT_RD] = bus.fft_rd_req & bus.fft_enable;
  assign w_eff_req[CH_FFT_WR] = bus.fft_wr_req & bus.fft_enable;
  assign w_eff_req[CH_FIR_RD] = bus.fir_rd_req & bus.fir_enable;
  assign w_eff_req[CH_FIR_WR] = bus.fir_wr_req & bus.fir_enable;

  assign w_ch_addr[CH_FFT_RD] = bus.fft_rd_addr;
  assign w_ch_addr[CH_FFT_WR] = bus.fft_wr_addr;
  assign w_ch_addr[CH_FIR_RD] = bus.fir_rd_addr;
  assign w_ch_addr[CH_FIR_WR] = bus.fir_wr_addr;

  rr_pick4 u_pick (
    .i_req    (w_eff_req),
    .i_rr_ptr (r_rr_ptr),
    .o_winner (w_pick),
    .o_valid  (w_pick_valid)
  );

  // A beat is any edge where the granted channel is still requesting.
  assign w_beat = (r_state == GRANT) & r_gnt[r_winner] & w_eff_req[r_winner];

  // Next-state logic: arbitration, turnaround countdown, burst accounting.
  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_last_dir_nxt = r_last_dir;
    w_beat_cnt_nxt = r_beat_cnt;
    w_turn_cnt_nxt = r_turn_cnt;
    w_winner_nxt   = r_winner;
    unique case (r_state)
      ARB: begin
        w_gnt_nxt = 4'b0;
        if (w_pick_valid) begin
          w_winner_nxt = w_pick;
          if (ch_dir(w_pick) == r_last_dir || TURN_CYCLES == 0) begin
            w_state_nxt = GRANT;
            w_gnt_nxt   = 4'b0001 << w_pick;
          end else begin
            w_state_nxt    = TURN;
            w_turn_cnt_nxt = 2'(TURN_CYCLES - 1);
          end
        end
      end
      TURN: begin
        w_gnt_nxt = 4'b0;
        if (!w_eff_req[r_winner]) begin
          w_state_nxt = ARB;
        end else if (r_turn_cnt == 2'd0) begin
          w_state_nxt = GRANT;
          w_gnt_nxt   = 4'b0001 << r_winner;
        end else begin
          w_turn_cnt_nxt = r_turn_cnt - 2'd1;
        end
      end
      GRANT: begin
        if (w_beat) begin
          w_beat_cnt_nxt = r_beat_cnt + 8'd1;
        end
        if (!w_beat || r_beat_cnt == 8'(MAX_BURST - 1)) begin
          w_state_nxt    = ARB;
          w_gnt_nxt      = 4'b0;
          w_rr_ptr_nxt   = r_winner;
          w_last_dir_nxt = ch_dir(r_winner);
          w_beat_cnt_nxt = 8'd0;
        end
      end
      default: begin
        w_state_nxt = ARB;
        w_gnt_nxt   = 4'b0;
      end
    endcase
  end

  // State register with synchronous reset; reset aborts any burst at once.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      r_state    <= ARB;
      r_gnt      <= 4'b0;
      r_rr_ptr   <= 2'd3;
      r_last_dir <= DIR_READ;
      r_beat_cnt <= 8'd0;
      r_turn_cnt <= 2'd0;
      r_winner   <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_last_dir <= w_last_dir_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_turn_cnt <= w_turn_cnt_nxt;
      r_winner   <= w_winner_nxt;
    end
  end

  // RAM port outputs follow the registered grant; idle port drives zeros.
  always_comb begin
    bus.addr             = '0;
    bus.ram_read_enable  = 1'b0;
    bus.ram_write_enable = 1'b0;
    if (r_state == GRANT && r_gnt != 4'b0) begin
      bus.addr             = w_ch_addr[r_winner];
      bus.ram_read_enable  = w_eff_req[r_winner] & (ch_dir(r_winner) == DIR_READ);
      bus.ram_write_enable = w_eff_req[r_winner] & (ch_dir(r_winner) == DIR_WRITE);
    end
  end

  assign bus.fft_rd_gnt = r_gnt[CH_FFT_RD];
  assign bus.fft_wr_gnt = r_gnt[CH_FFT_WR];
  assign bus.fir_rd_gnt = r_gnt[CH_FIR_RD];
  assign bus.fir_wr_gnt = r_gnt[CH_FIR_WR];
  assign bus.busy       = (|r_gnt) | (r_state == TURN);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: a cycle-level reference model
// predicts the port outputs each cycle, a monitor compares them.
module tb_ram_port_arbiter;

  localparam int ADDR_W      = 32;
  localparam int MAX_BURST   = 8;
  localparam int TURN_CYCLES = 2;
  localparam int N_CYCLES    = 900;

  typedef struct {
    int          cyc;
    logic [3:0]  gnt;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic        busy;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ram_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  ram_port_arbiter #(
    .ADDR_W      (ADDR_W),
    .MAX_BURST   (MAX_BURST),
    .TURN_CYCLES (TURN_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // Reference model state: who owns the port, who waits through turnaround.
  int          m_owner;
  int          m_cand;
  int          m_turn_left;
  int          m_ptr;
  int          m_last;
  int          m_beats;
  logic [31:0] ch_addr [4];

  task automatic check(input string name, input int cyc,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic exp_t model_outputs(input int cyc, input logic [3:0] eff);
    exp_t e;
    e.cyc = cyc; e.gnt = 4'b0; e.rd = 1'b0; e.wr = 1'b0; e.addr = '0; e.busy = 1'b0;
    if (m_owner >= 0) begin
      e.gnt  = 4'b0001 << m_owner;
      e.addr = ch_addr[m_owner];
      e.rd   = eff[m_owner] && (m_owner % 2 == 0);
      e.wr   = eff[m_owner] && (m_owner % 2 == 1);
      e.busy = 1'b1;
    end else if (m_cand >= 0) begin
      e.busy = 1'b1;
    end
    return e;
  endfunction

  task automatic model_step(input logic rst, input logic [3:0] eff);
    if (rst) begin
      m_owner = -1; m_cand = -1; m_turn_left = 0;
      m_ptr = 3; m_last = 0; m_beats = 0;
      return;
    end
    if (m_owner >= 0) begin
      if (eff[m_owner]) begin
        m_beats++;
        ch_addr[m_owner] = ch_addr[m_owner] + 32'd1;
      end
      if (!eff[m_owner] || m_beats == MAX_BURST) begin
        m_ptr = m_owner; m_last = m_owner % 2; m_beats = 0; m_owner = -1;
      end
    end else if (m_cand >= 0) begin
      if (!eff[m_cand]) m_cand = -1;
      else begin
        m_turn_left--;
        if (m_turn_left == 0) begin m_owner = m_cand; m_cand = -1; end
      end
    end else begin
      for (int j = 1; j <= 4; j++) begin
        int c;
        c = (m_ptr + j) % 4;
        if (eff[c]) begin
          if (c % 2 == m_last || TURN_CYCLES == 0) m_owner = c;
          else begin m_cand = c; m_turn_left = TURN_CYCLES; end
          break;
        end
      end
    end
  endtask

  // Monitor: compare DUT outputs with the oldest prediction, off the clock edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("grants", e.cyc, 32'({bus.fir_wr_gnt, bus.fir_rd_gnt, bus.fft_wr_gnt, bus.fft_rd_gnt}), 32'(e.gnt));
        check("ram_read_enable", e.cyc, 32'(bus.ram_read_enable), 32'(e.rd));
        check("ram_write_enable", e.cyc, 32'(bus.ram_write_enable), 32'(e.wr));
        check("addr", e.cyc, bus.addr, e.addr);
        check("busy", e.cyc, 32'(bus.busy), 32'(e.busy));
        check("rd_wr_exclusive", e.cyc, 32'(bus.ram_read_enable & bus.ram_write_enable), 32'd0);
      end
    end
  end

  // Driver: directed phases, then sticky random requests with enable drops
  // and occasional resets; each cycle pushes the model's prediction.
  initial begin
    logic [3:0] req;
    logic [3:0] eff;
    logic       fft_en, fir_en, rst;
    ch_addr[0] = 32'h0000_0100;
    ch_addr[1] = 32'h0000_2000;
    ch_addr[2] = 32'h0003_0000;
    ch_addr[3] = 32'h0040_0000;
    req = 4'b0; fft_en = 1'b1; fir_en = 1'b1;
    reset = 1'b1;
    bus.fft_enable = 1'b1; bus.fir_enable = 1'b1;
    bus.fft_rd_req = 1'b0; bus.fft_wr_req = 1'b0;
    bus.fir_rd_req = 1'b0; bus.fir_wr_req = 1'b0;
    bus.fft_rd_addr = ch_addr[0]; bus.fft_wr_addr = ch_addr[1];
    bus.fir_rd_addr = ch_addr[2]; bus.fir_wr_addr = ch_addr[3];
    model_step(1'b1, 4'b0);
    @(negedge clk);
    @(negedge clk);

    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      if (cyc != 0) @(negedge clk);
      rst = 1'b0; fft_en = 1'b1; fir_en = 1'b1;
      if (cyc < 30)       req = 4'b0001;            // sole FFT reader
      else if (cyc < 70)  req = 4'b0101;            // FFT rd vs FIR rd
      else if (cyc < 90)  req = 4'b1100;            // FIR rd then FIR wr turnaround
      else if (cyc < 130) begin                     // all four, reset mid-burst
        req = 4'b1111;
        rst = (cyc == 126);
      end else if (cyc < 150) begin                 // FFT write, enable drop
        req = 4'b0110;
        fft_en = !(cyc >= 137 && cyc < 140);
      end else begin
        for (int b = 0; b < 4; b++)
          if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
        fft_en = ($urandom_range(0, 15) != 0);
        fir_en = ($urandom_range(0, 15) != 0);
        rst    = ($urandom_range(0, 199) == 0);
      end
      reset = rst;
      bus.fft_enable = fft_en; bus.fir_enable = fir_en;
      bus.fft_rd_req = req[0]; bus.fft_wr_req = req[1];
      bus.fir_rd_req = req[2]; bus.fir_wr_req = req[3];
      bus.fft_rd_addr = ch_addr[0]; bus.fft_wr_addr = ch_addr[1];
      bus.fir_rd_addr = ch_addr[2]; bus.fir_wr_addr = ch_addr[3];
      eff = req & {fir_en, fir_en, fft_en, fft_en};
      exp_q.push_back(model_outputs(cyc, eff));
      model_step(rst, eff);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", N_CYCLES, 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
